// File: rtl/max_stream.sv
`default_nettype none
// ============================================================================
// Module   : max_stream
// Brief    : Per-frame maximum over a valid/ready element stream, with sticky
//            overflow flag; argmax tracking and out_idx enabled by the macro
//            MAX_STREAM_ARGMAX_EN.
// Revision : 1.0 - initial release
// ============================================================================
module max_stream #(
  parameter int WIDTH = 3,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
`ifdef MAX_STREAM_ARGMAX_EN
  output logic [IDX_W-1:0] out_idx,
`endif
  output logic             out_ovf
);

  localparam logic [0:0]       c_st_first = 1'b0;
  localparam logic [0:0]       c_st_accum = 1'b1;
  localparam logic [IDX_W-1:0] c_cnt_max  = {IDX_W{1'b1}};

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_max;
  logic [IDX_W-1:0] r_cnt;
  logic             r_full;
  logic             r_ovf;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_max;
  logic             r_out_ovf;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_gt;
  logic [WIDTH-1:0] w_max_nxt;
  logic             w_ovf_nxt;

  assign in_ready   = ~r_out_valid | out_ready;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  assign out_valid  = r_out_valid;
  assign out_max    = r_out_max;
  assign out_ovf    = r_out_ovf;

  // Merged result including the current beat; strict compare keeps earliest tie.
  always_comb begin
    w_gt      = 1'b0;
    w_max_nxt = in_data;
    w_ovf_nxt = 1'b0;
    if (r_state == c_st_accum) begin
      w_gt      = (in_data > r_max);
      w_max_nxt = w_gt ? in_data : r_max;
      w_ovf_nxt = r_ovf | r_full;
    end
  end

  // r_full marks that position 2^IDX_W-1 was consumed, so any later beat overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_st_first;
      r_max       <= '0;
      r_cnt       <= '0;
      r_full      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_max   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      if (w_in_fire) begin
        if (in_last) begin
          r_state   <= c_st_first;
          r_out_max <= w_max_nxt;
          r_out_ovf <= w_ovf_nxt;
        end else begin
          r_state <= c_st_accum;
          r_max   <= w_max_nxt;
          r_ovf   <= w_ovf_nxt;
          if (r_state == c_st_first) begin
            r_cnt  <= IDX_W'(1);
            r_full <= 1'b0;
          end else if (r_cnt == c_cnt_max) begin
            r_full <= 1'b1;
          end else begin
            r_cnt <= r_cnt + IDX_W'(1);
          end
        end
      end
      if (w_in_fire && in_last) begin
        r_out_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef MAX_STREAM_ARGMAX_EN
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_out_idx;
  logic [IDX_W-1:0] w_idx_nxt;

  assign out_idx = r_out_idx;

  // r_cnt stops at its saturated value, which clamps the index on overflow.
  always_comb begin
    w_idx_nxt = '0;
    if (r_state == c_st_accum) begin
      w_idx_nxt = w_gt ? r_cnt : r_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_out_idx <= '0;
    end else if (w_in_fire) begin
      if (in_last) begin
        r_out_idx <= w_idx_nxt;
      end else begin
        r_idx <= w_idx_nxt;
      end
    end
  end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_max_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_max_stream
// Brief    : Directed self-checking bench for max_stream (default and IDX_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_max_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic       in_ready0, out_valid0, out_ovf0;
  logic [2:0] out_max0;
  logic       in_ready1, out_valid1, out_ovf1;
  logic [2:0] out_max1;
`ifdef MAX_STREAM_ARGMAX_EN
  logic [3:0] out_idx0;
  logic [1:0] out_idx1;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  max_stream #(.WIDTH(3), .IDX_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid0),
    .out_ready(out_ready), .out_max(out_max0),
`ifdef MAX_STREAM_ARGMAX_EN
    .out_idx(out_idx0),
`endif
    .out_ovf(out_ovf0)
  );

  max_stream #(.WIDTH(3), .IDX_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid1),
    .out_ready(out_ready), .out_max(out_max1),
`ifdef MAX_STREAM_ARGMAX_EN
    .out_idx(out_idx1),
`endif
    .out_ovf(out_ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] d, input logic l);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid0), 32'd0);
    chk("rst_max",   32'(out_max0),   32'd0);
    chk("rst_ovf",   32'(out_ovf0),   32'd0);
    chk("rst_ready", 32'(in_ready0),  32'd1);
`ifdef MAX_STREAM_ARGMAX_EN
    chk("rst_idx",   32'(out_idx0),   32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Frame 3,5,2,7,1
    send(3'd3, 1'b0); send(3'd5, 1'b0); send(3'd2, 1'b0); send(3'd7, 1'b0);
    chk("f1_pre_valid", 32'(out_valid0), 32'd0);
    send(3'd1, 1'b1);
    chk("f1_valid", 32'(out_valid0), 32'd1);
    chk("f1_max",   32'(out_max0),   32'd7);
    chk("f1_ovf",   32'(out_ovf0),   32'd0);
`ifdef MAX_STREAM_ARGMAX_EN
    chk("f1_idx",   32'(out_idx0),   32'd3);
`endif
    idle();
    chk("f1_drain", 32'(out_valid0), 32'd0);

    // Single-beat frame, then tie frame
    send(3'd4, 1'b1);
    chk("single_valid", 32'(out_valid0), 32'd1);
    chk("single_max",   32'(out_max0),   32'd4);
`ifdef MAX_STREAM_ARGMAX_EN
    chk("single_idx",   32'(out_idx0),   32'd0);
`endif
    send(3'd6, 1'b0); send(3'd6, 1'b0); send(3'd6, 1'b1);
    chk("tie_max", 32'(out_max0), 32'd6);
`ifdef MAX_STREAM_ARGMAX_EN
    chk("tie_idx", 32'(out_idx0), 32'd0);
`endif
    idle();
    chk("tie_drain", 32'(out_valid0), 32'd0);

    // Backpressure: hold result 7, stall a new frame, then release with last beat
    @(negedge clk);
    out_ready = 1'b0;
    send(3'd7, 1'b1);
    chk("bp_ready",  32'(in_ready0), 32'd0);
    chk("bp_max",    32'(out_max0),  32'd7);
    @(negedge clk);
    in_valid = 1'b1; in_data = 3'd3; in_last = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_hold_max",   32'(out_max0),   32'd7);
    chk("bp_hold_valid", 32'(out_valid0), 32'd1);
    chk("bp_hold_ready", 32'(in_ready0),  32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("b2b_valid", 32'(out_valid0), 32'd1);
    chk("b2b_max",   32'(out_max0),   32'd3);
    idle();
    chk("b2b_drain", 32'(out_valid0), 32'd0);

    // Overflow: 5 beats exceed 2^2 on the narrow instance only
    send(3'd1, 1'b0); send(3'd1, 1'b0); send(3'd1, 1'b0); send(3'd1, 1'b0);
    send(3'd7, 1'b1);
    chk("ovf1_flag", 32'(out_ovf1), 32'd1);
    chk("ovf1_max",  32'(out_max1), 32'd7);
    chk("ovf0_flag", 32'(out_ovf0), 32'd0);
    chk("ovf0_max",  32'(out_max0), 32'd7);
`ifdef MAX_STREAM_ARGMAX_EN
    chk("ovf1_idx",  32'(out_idx1), 32'd3);
    chk("ovf0_idx",  32'(out_idx0), 32'd4);
`endif
    // Exactly 2^2 beats is not an overflow
    send(3'd0, 1'b0); send(3'd1, 1'b0); send(3'd2, 1'b0); send(3'd5, 1'b1);
    chk("full1_flag", 32'(out_ovf1), 32'd0);
    chk("full1_max",  32'(out_max1), 32'd5);
`ifdef MAX_STREAM_ARGMAX_EN
    chk("full1_idx",  32'(out_idx1), 32'd3);
`endif

    // Reset mid-frame discards the partial frame
    send(3'd6, 1'b0); send(3'd7, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle();
    chk("abort_valid", 32'(out_valid0), 32'd0);
    chk("abort_max",   32'(out_max0),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(3'd2, 1'b1);
    chk("abort_f_valid", 32'(out_valid0), 32'd1);
    chk("abort_f_max",   32'(out_max0),   32'd2);
    chk("abort_f_ovf",   32'(out_ovf0),   32'd0);
`ifdef MAX_STREAM_ARGMAX_EN
    chk("abort_f_idx",   32'(out_idx0),   32'd0);
`endif

    // Reset wins over a held result and a simultaneous last beat
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 3'd5; in_last = 1'b1;
    idle();
    chk("rstpri_valid", 32'(out_valid0), 32'd0);
    chk("rstpri_max",   32'(out_max0),   32'd0);
    chk("rstpri_ready", 32'(in_ready0),  32'd1);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    idle();
    chk("rstpri_idle", 32'(out_valid0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
